// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg7_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Element k is the active-low {g,f,e,d,c,b,a} pattern for hex digit k.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble to active-low 7-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = HEX_SEG[hex_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit time-multiplexed 7-segment scanner with frame-aligned data load.
//
// state | meaning
// BLANK | all anodes off for BLANK_CYCLES before digit idx
// SHOW  | digit idx driven for DWELL_CYCLES (dark if its enable is clear)
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned CNT_W        = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digit_val,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic        load_ack,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic        frame_start
);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [15:0]       val_q, val_d;
  logic [3:0]        en_q, en_d;
  logic [3:0]        dp_q, dp_d;
  logic              pend_q, pend_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dpn_q, dpn_d;
  logic              boundary;
  logic              take;
  logic [3:0]        nib;
  logic [6:0]        nib_seg;

  // Boundary is decoded from registered state so it coincides with the
  // first post-reset cycle; the capture acknowledges a same-cycle load.
  assign boundary    = (state_q == BLANK) && (idx_q == 2'd0) && (timer_q == '0) && !rst;
  assign take        = boundary && (pend_q || load);
  assign frame_start = boundary;
  assign load_ack    = take;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q + 1'b1;
    if (state_q == BLANK) begin
      if (timer_q == BLANK_LAST) begin
        state_d = SHOW;
        timer_d = '0;
      end
    end else begin
      if (timer_q == DWELL_LAST) begin
        state_d = BLANK;
        idx_d   = idx_q + 2'd1;
        timer_d = '0;
      end
    end
  end

  always_comb begin
    val_d  = take ? digit_val : val_q;
    en_d   = take ? digit_en  : en_q;
    dp_d   = take ? dp_in     : dp_q;
    pend_d = take ? 1'b0      : (pend_q | load);
  end

  assign nib = val_d[{idx_d, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .hex_i   (nib),
    .seg_n_o (nib_seg)
  );

  // Outputs are computed from next state so anode and segments switch together.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dpn_d = 1'b1;
    if (state_d == SHOW && en_d[idx_d]) begin
      an_d  = ~(4'b0001 << idx_d);
      seg_d = nib_seg;
      dpn_d = ~dp_d[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BLANK;
      idx_q   <= 2'd0;
      timer_q <= '0;
      val_q   <= '0;
      en_q    <= '0;
      dp_q    <= '0;
      pend_q  <= 1'b0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dpn_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      val_q   <= val_d;
      en_q    <= en_d;
      dp_q    <= dp_d;
      pend_q  <= pend_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dpn_q   <= dpn_d;
    end
  end

  assign an_n  = an_q;
  assign seg_n = seg_q;
  assign dp_n  = dpn_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: frame-position reference model plus directed and table checks.
module tb_seg7_scan_ctrl;

  localparam int DW    = 8;
  localparam int BL    = 2;
  localparam int SLOT  = DW + BL;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digit_val = '0;
  logic [3:0]  digit_en = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        load_ack;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_start;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BL),
    .CNT_W        (17)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .digit_val   (digit_val),
    .digit_en    (digit_en),
    .dp_in       (dp_in),
    .load        (load),
    .load_ack    (load_ack),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .an_n        (an_n),
    .frame_start (frame_start)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state: cycles since reset release plus shadow copy
  int          m_t = 0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_en = '0;
  logic [3:0]  m_dp = '0;
  logic        m_pend = 1'b0;

  logic [3:0] snap_an;
  logic [6:0] snap_seg;
  logic       snap_dp, snap_fs, snap_ack;

  logic [3:0] cap_an  [0:FRAME];
  logic [6:0] cap_seg [0:FRAME];
  logic       cap_dp  [0:FRAME];
  logic       cap_fs  [0:FRAME];

  typedef struct {
    logic [3:0] nib;
    logic [6:0] seg;
  } vec_t;
  vec_t vecs [16];

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample and compare against the model at negedge, then
  // advance to just after the next posedge where new inputs may be driven.
  task automatic tick();
    int p, slot, w;
    logic tk;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_fs;
    @(negedge clk);
    snap_an  = an_n;
    snap_seg = seg_n;
    snap_dp  = dp_n;
    snap_fs  = frame_start;
    snap_ack = load_ack;
    if (rst) begin
      m_t = 0; m_val = '0; m_en = '0; m_dp = '0; m_pend = 1'b0;
    end else begin
      p    = m_t % FRAME;
      slot = p / SLOT;
      w    = p % SLOT;
      e_fs = (p == 0);
      tk   = e_fs && (m_pend || load);
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      if (w >= BL && m_en[slot]) begin
        e_an  = 4'hF & ~(4'(1) << slot);
        e_seg = seg_of(m_val[slot*4 +: 4]);
        e_dp  = ~m_dp[slot];
      end
      n_tests++;
      if ({snap_an, snap_seg, snap_dp, snap_fs, snap_ack} !== {e_an, e_seg, e_dp, e_fs, tk}) begin
        n_fail++;
        $display("FAIL model t=%0d: got an=%h seg=%h dp=%b fs=%b ack=%b expected an=%h seg=%h dp=%b fs=%b ack=%b",
                 m_t, snap_an, snap_seg, snap_dp, snap_fs, snap_ack, e_an, e_seg, e_dp, e_fs, tk);
      end
      if (tk) begin
        m_val = digit_val; m_en = digit_en; m_dp = dp_in; m_pend = 1'b0;
      end else begin
        m_pend = m_pend | load;
      end
      m_t++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_boundary(output int acks);
    bit ok;
    acks = 0;
    ok = 1'b0;
    for (int i = 0; i < FRAME + 5; i++) begin
      tick();
      if (snap_ack) acks++;
      if (snap_fs) begin
        ok = 1'b1;
        break;
      end
    end
    check("boundary_seen", 32'(ok), 32'd1);
  endtask

  // Call on a boundary cycle; index 0 is that cycle, index FRAME the next boundary.
  task automatic capture_frame();
    cap_an[0] = snap_an; cap_seg[0] = snap_seg; cap_dp[0] = snap_dp; cap_fs[0] = snap_fs;
    for (int i = 1; i <= FRAME; i++) begin
      tick();
      cap_an[i] = snap_an; cap_seg[i] = snap_seg; cap_dp[i] = snap_dp; cap_fs[i] = snap_fs;
    end
  endtask

  initial begin
    int acks, cnt;

    for (int i = 0; i < 16; i++) vecs[i].nib = 4'(i);
    vecs[0].seg  = 7'h40; vecs[1].seg  = 7'h79; vecs[2].seg  = 7'h24; vecs[3].seg  = 7'h30;
    vecs[4].seg  = 7'h19; vecs[5].seg  = 7'h12; vecs[6].seg  = 7'h02; vecs[7].seg  = 7'h78;
    vecs[8].seg  = 7'h00; vecs[9].seg  = 7'h10; vecs[10].seg = 7'h08; vecs[11].seg = 7'h03;
    vecs[12].seg = 7'h46; vecs[13].seg = 7'h21; vecs[14].seg = 7'h06; vecs[15].seg = 7'h0E;

    // reset and dark frame without load
    rst = 1'b1;
    repeat (3) tick();
    check("rst_an", 32'(snap_an), 32'hF);
    check("rst_seg", 32'(snap_seg), 32'h7F);
    check("rst_dp", 32'(snap_dp), 32'd1);
    check("rst_fs", 32'(snap_fs), 32'd0);
    check("rst_ack", 32'(snap_ack), 32'd0);
    rst = 1'b0;
    tick();
    check("fs_after_release", 32'(snap_fs), 32'd1);
    cnt = 0;
    repeat (FRAME - 5) begin
      tick();
      if (snap_an != 4'hF) cnt++;
    end
    check("dark_without_load", 32'(cnt), 32'd0);

    // basic load of 1234
    digit_val = 16'h1234; digit_en = 4'hF; dp_in = 4'h0;
    load = 1'b1;
    tick();
    load = 1'b0;
    wait_boundary(acks);
    check("t2_ack_on_boundary", 32'(snap_ack), 32'd1);
    capture_frame();
    check("t2_blank1_an", 32'(cap_an[1]), 32'hF);
    check("t2_d0_an", 32'(cap_an[2]), 32'hE);
    check("t2_d0_seg", 32'(cap_seg[2]), 32'h19);
    check("t2_d0_last_an", 32'(cap_an[9]), 32'hE);
    check("t2_gap_an", 32'(cap_an[10]), 32'hF);
    check("t2_d1", 32'({cap_an[12], cap_seg[12]}), 32'({4'hD, 7'h30}));
    check("t2_d2", 32'({cap_an[22], cap_seg[22]}), 32'({4'hB, 7'h24}));
    check("t2_d3", 32'({cap_an[32], cap_seg[32]}), 32'({4'h7, 7'h79}));

    // reset pulsed during digit 2 SHOW
    repeat (25) tick();
    check("pre_rst_d2_an", 32'(snap_an), 32'hB);
    rst = 1'b1;
    tick();
    tick();
    check("midrst_an", 32'(snap_an), 32'hF);
    check("midrst_seg", 32'(snap_seg), 32'h7F);
    check("midrst_dp", 32'(snap_dp), 32'd1);
    rst = 1'b0;
    tick();
    check("midrst_fs_after_release", 32'(snap_fs), 32'd1);
    cnt = 0;
    repeat (FRAME - 5) begin
      tick();
      if (snap_an != 4'hF) cnt++;
    end
    check("midrst_dark", 32'(cnt), 32'd0);

    // two requests in one frame, data changed before boundary
    wait_boundary(acks);
    cnt = 0;
    repeat (3) begin tick(); cnt += int'(snap_ack); end
    load = 1'b1; tick(); cnt += int'(snap_ack);
    load = 1'b0;
    repeat (4) begin tick(); cnt += int'(snap_ack); end
    load = 1'b1; tick(); cnt += int'(snap_ack);
    load = 1'b0;
    digit_val = 16'hABCD;
    wait_boundary(acks);
    check("t3_single_ack", 32'(cnt + acks), 32'd1);
    check("t3_ack_on_boundary", 32'(snap_ack), 32'd1);
    capture_frame();
    check("t3_d0_seg", 32'(cap_seg[2]), 32'h21);
    check("t3_d1_seg", 32'(cap_seg[12]), 32'h46);

    // disabled digit keeps its slot dark; frame period unchanged
    digit_en = 4'b1011;
    load = 1'b1;
    wait_boundary(acks);
    load = 1'b0;
    check("t4_ack", 32'(snap_ack), 32'd1);
    capture_frame();
    cnt = 0;
    for (int i = 22; i < 30; i++) if (cap_an[i] != 4'hF) cnt++;
    check("t4_d2_dark", 32'(cnt), 32'd0);
    check("t4_d3_lit", 32'(cap_an[32]), 32'h7);
    cnt = 0;
    for (int i = 1; i < FRAME; i++) if (cap_fs[i]) cnt++;
    check("t4_no_early_fs", 32'(cnt), 32'd0);
    check("t4_fs_period", 32'(cap_fs[FRAME]), 32'd1);

    // load on the boundary cycle itself, with decimal point on digit 0
    repeat (FRAME - 1) tick();
    digit_val = 16'h0005; digit_en = 4'hF; dp_in = 4'b0001;
    load = 1'b1;
    tick();
    check("t5_fs", 32'(snap_fs), 32'd1);
    check("t5_ack_same_cycle", 32'(snap_ack), 32'd1);
    load = 1'b0;
    tick();
    check("t5_blank", 32'(snap_an), 32'hF);
    tick();
    check("t5_new_val", 32'({snap_an, snap_seg, snap_dp}), 32'({4'hE, 7'h12, 1'b0}));
    wait_boundary(acks);
    capture_frame();
    cnt = 0;
    for (int i = 0; i < FRAME; i++)
      if (cap_dp[i] !== ((i >= BL && i < SLOT) ? 1'b0 : 1'b1)) cnt++;
    check("t6_dp_only_digit0", 32'(cnt), 32'd0);

    // decode table through digit 0
    dp_in = 4'h0; digit_en = 4'hF;
    for (int v = 0; v < 16; v++) begin
      digit_val = {4{vecs[v].nib}};
      load = 1'b1;
      wait_boundary(acks);
      load = 1'b0;
      check("vec_ack", 32'(snap_ack), 32'd1);
      tick();
      tick();
      check($sformatf("vec_seg_%0h", vecs[v].nib), 32'(snap_seg), 32'(vecs[v].seg));
    end

    // randomized traffic against the model
    repeat (600) begin
      digit_val = 16'($urandom);
      digit_en  = 4'($urandom);
      dp_in     = 4'($urandom);
      load      = ($urandom_range(0, 5) == 0);
      rst       = ($urandom_range(0, 249) == 0);
      tick();
    end
    rst = 1'b0; load = 1'b0;
    repeat (FRAME) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
